// File: rtl/xst_pkg.sv
// ============================================================================
// Module : xst_pkg
// Brief  : Shared widths and FSM state encoding for the xst transfer scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package xst_pkg;

    localparam int XST_WIDTH  = 64;
    localparam int XST_BITS_W = 6;
    localparam int XST_BAUD_W = 16;

    localparam int ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [ST_W-1:0] ST_LOAD    = 3'd1;
    localparam logic [ST_W-1:0] ST_SETTLE  = 3'd2;
    localparam logic [ST_W-1:0] ST_BUSY    = 3'd3;
    localparam logic [ST_W-1:0] ST_CAPTURE = 3'd4;
    localparam logic [ST_W-1:0] ST_RESP    = 3'd5;

endpackage : xst_pkg

`default_nettype wire

// File: rtl/xst_sched_if.sv
// ============================================================================
// Module : xst_sched_if
// Brief  : Requester, response and engine-side signal bundle of xst_sched.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface xst_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) ();

    logic [NREQ-1:0]                      req_i;
    logic [NREQ*xst_pkg::XST_WIDTH-1:0]   req_dat_i;
    logic [NREQ*xst_pkg::XST_BITS_W-1:0]  req_bits_i;
    logic [NREQ*xst_pkg::XST_BAUD_W-1:0]  req_baud_i;
    logic [NREQ-1:0]                      gnt_o;

    logic                                 rsp_valid_o;
    logic                                 rsp_ready_i;
    logic [IDW-1:0]                       rsp_id_o;
    logic [xst_pkg::XST_WIDTH-1:0]        rsp_dat_o;

    logic                                 xst_we_o;
    logic                                 xst_oe_o;
    logic [xst_pkg::XST_WIDTH-1:0]        xst_dat_o;
    logic [xst_pkg::XST_BITS_W-1:0]       xst_bits_o;
    logic [xst_pkg::XST_BAUD_W-1:0]       xst_baud_o;
    logic                                 xst_idle_i;
    logic [xst_pkg::XST_WIDTH-1:0]        xst_dat_i;

    logic                                 busy_o;

    modport slave (
        input  req_i, req_dat_i, req_bits_i, req_baud_i, rsp_ready_i,
               xst_idle_i, xst_dat_i,
        output gnt_o, rsp_valid_o, rsp_id_o, rsp_dat_o, xst_we_o, xst_oe_o,
               xst_dat_o, xst_bits_o, xst_baud_o, busy_o
    );

    modport master (
        output req_i, req_dat_i, req_bits_i, req_baud_i, rsp_ready_i,
               xst_idle_i, xst_dat_i,
        input  gnt_o, rsp_valid_o, rsp_id_o, rsp_dat_o, xst_we_o, xst_oe_o,
               xst_dat_o, xst_bits_o, xst_baud_o, busy_o
    );

endinterface : xst_sched_if

`default_nettype wire

// File: rtl/xst_rr_arb.sv
// ============================================================================
// Module : xst_rr_arb
// Brief  : Combinational round-robin pick; search begins at i_ptr and wraps.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module xst_rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  wire logic [NREQ-1:0] i_req,
    input  wire logic [IDW-1:0]  i_ptr,
    output logic                 o_valid,
    output logic [NREQ-1:0]      o_onehot,
    output logic [IDW-1:0]       o_idx
);

    logic [IDW-1:0] w_cand;

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_cand = IDW'((int'(i_ptr) + i) % NREQ);
            if (!o_valid && i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

    assign o_onehot = o_valid ? (NREQ'(1) << o_idx) : '0;

endmodule : xst_rr_arb

`default_nettype wire

// File: rtl/xst_sched.sv
// ============================================================================
// Module : xst_sched
// Brief  : Round-robin scheduler sharing one xst serial engine among NREQ
//          requesters. XST_SCHED_ALIGN_EN right-justifies captured data.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module xst_sched
    import xst_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  wire logic  clk_i,
    input  wire logic  reset_ni,
    xst_sched_if.slave bus
);

    logic [ST_W-1:0]       r_state;
    logic [ST_W-1:0]       w_next;
    logic [IDW-1:0]        r_ptr;
    logic [IDW-1:0]        r_win;
    logic [NREQ-1:0]       r_win_oh;
    logic [XST_BITS_W-1:0] r_bits;
    logic [IDW-1:0]        r_rsp_id;
    logic [XST_WIDTH-1:0]  r_rsp_dat;
    logic [XST_WIDTH-1:0]  w_cap_dat;

    logic                  w_arb_vld;
    logic [NREQ-1:0]       w_arb_oh;
    logic [IDW-1:0]        w_arb_idx;
    logic                  w_grant;

    xst_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .i_req    (bus.req_i),
        .i_ptr    (r_ptr),
        .o_valid  (w_arb_vld),
        .o_onehot (w_arb_oh),
        .o_idx    (w_arb_idx)
    );

    assign w_grant = (r_state == ST_IDLE) && w_arb_vld && bus.xst_idle_i;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) r_state <= ST_IDLE;
        else           r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (w_grant) w_next = ST_LOAD;
            ST_LOAD:    w_next = ST_SETTLE;
            ST_SETTLE:  w_next = ST_BUSY;
            ST_BUSY:    if (bus.xst_idle_i) w_next = ST_CAPTURE;
            ST_CAPTURE: w_next = ST_RESP;
            ST_RESP:    if (bus.rsp_ready_i) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

`ifdef XST_SCHED_ALIGN_EN
    // received bits arrive at the top of the shift register; move them to bit 0
    assign w_cap_dat = (r_bits == '0) ? bus.xst_dat_i
                     : bus.xst_dat_i >> (7'd64 - {1'b0, r_bits});
`else
    logic w_unused_bits;
    assign w_unused_bits = ^r_bits;
    assign w_cap_dat     = bus.xst_dat_i;
`endif

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_ptr     <= '0;
            r_win     <= '0;
            r_win_oh  <= '0;
            r_bits    <= '0;
            r_rsp_id  <= '0;
            r_rsp_dat <= '0;
        end else begin
            if (w_grant) begin
                r_win    <= w_arb_idx;
                r_win_oh <= w_arb_oh;
                r_ptr    <= (w_arb_idx == IDW'(NREQ - 1)) ? '0 : w_arb_idx + IDW'(1);
            end
            if (r_state == ST_LOAD)
                r_bits <= bus.req_bits_i[int'(r_win) * XST_BITS_W +: XST_BITS_W];
            if (r_state == ST_CAPTURE) begin
                r_rsp_dat <= w_cap_dat;
                r_rsp_id  <= r_win;
            end
        end
    end

    always_comb begin
        bus.gnt_o       = '0;
        bus.xst_we_o    = 1'b0;
        bus.xst_oe_o    = 1'b0;
        bus.xst_dat_o   = '0;
        bus.xst_bits_o  = '0;
        bus.xst_baud_o  = '0;
        bus.rsp_valid_o = 1'b0;
        bus.busy_o      = (r_state != ST_IDLE);
        case (r_state)
            ST_LOAD: begin
                bus.gnt_o      = r_win_oh;
                bus.xst_we_o   = 1'b1;
                bus.xst_dat_o  = bus.req_dat_i[int'(r_win) * XST_WIDTH +: XST_WIDTH];
                bus.xst_bits_o = bus.req_bits_i[int'(r_win) * XST_BITS_W +: XST_BITS_W];
                bus.xst_baud_o = bus.req_baud_i[int'(r_win) * XST_BAUD_W +: XST_BAUD_W];
            end
            ST_CAPTURE: bus.xst_oe_o    = 1'b1;
            ST_RESP:    bus.rsp_valid_o = 1'b1;
            default: ;
        endcase
    end

    assign bus.rsp_id_o  = r_rsp_id;
    assign bus.rsp_dat_o = r_rsp_dat;

endmodule : xst_sched

`default_nettype wire

// File: tb/tb_xst_sched.sv
// ============================================================================
// Module : tb_xst_sched
// Brief  : Self-checking bench for xst_sched with a loopback engine model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_xst_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef struct {
        logic [3:0]  g;
        logic [63:0] pd;
        logic [5:0]  pb;
        logic [15:0] pbaud;
        int          lat_g;
        int          lat_r;
        logic [3:0]  g_nxt;
        logic        we_nxt;
        logic [63:0] pd_nxt;
        logic [1:0]  rid;
        logic [63:0] rdat;
        bit          tmo;
    } xres_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    int   m_ptr;
    logic eng_hold;
    logic [63:0] eng_sh;
    logic [5:0]  eng_cnt;
    logic [63:0] t_dat  [NREQ];
    logic [5:0]  t_bits [NREQ];
    logic [15:0] t_baud [NREQ];

    xst_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    xst_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Loopback engine: one bit per clock, txd fed straight back into rxd at bit 63
    always @(posedge clk) begin
        if (bus.xst_we_o) begin
            eng_sh  <= bus.xst_dat_o;
            eng_cnt <= bus.xst_bits_o;
        end else if (eng_cnt != 0) begin
            eng_sh  <= {eng_sh[0], eng_sh[63:1]};
            eng_cnt <= eng_cnt - 6'd1;
        end
    end
    assign bus.xst_idle_i = (eng_cnt == 0) && !eng_hold;
    assign bus.xst_dat_i  = eng_sh;

    function automatic logic [63:0] exp_rsp(input logic [63:0] dat, input int b);
        logic [63:0] ones;
        ones = '1;
`ifdef XST_SCHED_ALIGN_EN
        return (b == 0) ? dat : (dat & (ones >> (64 - b)));
`else
        return (b == 0) ? dat : ((dat >> b) | (dat << (64 - b)));
`endif
    endfunction

    function automatic int exp_lat(input int b);
        return 3 + ((b == 0) ? 1 : b);
    endfunction

    // Round-robin reference; advances the model pointer on every grant
    function automatic int rr_pick(input logic [3:0] mask);
        for (int i = 0; i < NREQ; i++) begin
            int k;
            k = (m_ptr + i) % NREQ;
            if (mask[k]) begin
                m_ptr = (k + 1) % NREQ;
                return k;
            end
        end
        return -1;
    endfunction

    task automatic set_req(input int k, input logic [63:0] d, input logic [5:0] b, input logic [15:0] bd);
        t_dat[k] = d; t_bits[k] = b; t_baud[k] = bd;
        bus.req_dat_i[64*k +: 64]  = d;
        bus.req_bits_i[6*k +: 6]   = b;
        bus.req_baud_i[16*k +: 16] = bd;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_i = '0;
        bus.rsp_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
    endtask

    // Call from a negedge with requests already driven; returns at the first RESP negedge
    task automatic xfer(input bit drop, output xres_t r);
        r = '{default: '0};
        do begin @(negedge clk); r.lat_g++; end while (bus.gnt_o == 0 && r.lat_g < 20);
        if (bus.gnt_o == 0) begin r.tmo = 1; return; end
        r.g = bus.gnt_o; r.pd = bus.xst_dat_o; r.pb = bus.xst_bits_o; r.pbaud = bus.xst_baud_o;
        if (drop) bus.req_i = bus.req_i & ~r.g;
        @(negedge clk);
        r.lat_r = 1; r.g_nxt = bus.gnt_o; r.we_nxt = bus.xst_we_o; r.pd_nxt = bus.xst_dat_o;
        while (!bus.rsp_valid_o && r.lat_r < 200) begin @(negedge clk); r.lat_r++; end
        if (!bus.rsp_valid_o) r.tmo = 1;
        r.rid = bus.rsp_id_o; r.rdat = bus.rsp_dat_o;
    endtask

    task automatic handshake();
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_i = '0;
        bus.rsp_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.gnt_o, bus.rsp_valid_o, bus.xst_we_o, bus.xst_oe_o, bus.busy_o} !== 8'h00)
            $display("FAIL reset_ctrl: gnt/valid/we/oe/busy=%b want 0", {bus.gnt_o, bus.rsp_valid_o, bus.xst_we_o, bus.xst_oe_o, bus.busy_o});
        else n_pass++;
        n_checks++;
        if (bus.rsp_dat_o !== 64'h0 || bus.rsp_id_o !== 2'd0)
            $display("FAIL reset_rsp: dat=%h id=%0d want 0/0", bus.rsp_dat_o, bus.rsp_id_o);
        else n_pass++;
        rst_n = 1'b1;
        m_ptr = 0;
        @(negedge clk);
    endtask

    task automatic test_single();
        xres_t r;
        int w;
        set_req(2, 64'h00FF, 6'd8, 16'd4);
        bus.req_i = 4'b0100;
        w = rr_pick(bus.req_i);
        xfer(1'b1, r);
        n_checks++;
        if (r.tmo || r.g !== 4'b0100 || r.lat_g != 1)
            $display("FAIL single_gnt: gnt=%b lat=%0d tmo=%0d want 0100/1/0", r.g, r.lat_g, r.tmo);
        else n_pass++;
        n_checks++;
        if (r.pd !== 64'h00FF || r.pb !== 6'd8 || r.pbaud !== 16'd4)
            $display("FAIL single_payload: dat=%h bits=%0d baud=%0d want 00ff/8/4", r.pd, r.pb, r.pbaud);
        else n_pass++;
        n_checks++;
        if (r.g_nxt !== 4'b0000 || r.we_nxt !== 1'b0 || r.pd_nxt !== 64'h0)
            $display("FAIL single_pulse: gnt=%b we=%b dat=%h one cycle later want 0", r.g_nxt, r.we_nxt, r.pd_nxt);
        else n_pass++;
        n_checks++;
        if (r.rid !== 2'(w) || r.rdat !== exp_rsp(64'h00FF, 8) || r.lat_r != exp_lat(8))
            $display("FAIL single_rsp: id=%0d dat=%h lat=%0d want %0d/%h/%0d", r.rid, r.rdat, r.lat_r, w, exp_rsp(64'h00FF, 8), exp_lat(8));
        else n_pass++;
        handshake();
        n_checks++;
        if (bus.rsp_valid_o !== 1'b0 || bus.busy_o !== 1'b0)
            $display("FAIL single_done: valid=%b busy=%b want 0/0", bus.rsp_valid_o, bus.busy_o);
        else n_pass++;
    endtask

    task automatic test_zero_bits();
        xres_t r;
        set_req(0, 64'h1234, 6'd0, 16'd1);
        bus.req_i = 4'b0001;
        void'(rr_pick(bus.req_i));
        xfer(1'b1, r);
        n_checks++;
        if (r.tmo || r.lat_r != 4 || r.rdat !== 64'h1234)
            $display("FAIL zero_bits: lat=%0d dat=%h tmo=%0d want 4/1234/0", r.lat_r, r.rdat, r.tmo);
        else n_pass++;
        handshake();
    endtask

    task automatic test_align();
        xres_t r;
        set_req(1, 64'hA5, 6'd8, 16'd2);
        bus.req_i = 4'b0010;
        void'(rr_pick(bus.req_i));
        xfer(1'b1, r);
        n_checks++;
`ifdef XST_SCHED_ALIGN_EN
        if (r.tmo || r.rdat !== 64'hA5 || r.rid !== 2'd1)
            $display("FAIL align_a5: dat=%h id=%0d want a5/1", r.rdat, r.rid);
`else
        if (r.tmo || r.rdat !== 64'hA500_0000_0000_0000 || r.rid !== 2'd1)
            $display("FAIL align_a5: dat=%h id=%0d want a500000000000000/1", r.rdat, r.rid);
`endif
        else n_pass++;
        handshake();
    endtask

    task automatic test_round_robin();
        xres_t r;
        int w;
        int order [5] = '{0, 1, 2, 3, 0};
        do_reset();
        for (int k = 0; k < NREQ; k++) set_req(k, 64'(k + 1), 6'd1, 16'd1);
        bus.req_i = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            w = rr_pick(bus.req_i);
            xfer(1'b0, r);
            n_checks++;
            if (r.tmo || r.g !== 4'(1 << order[i]) || w != order[i] || r.rid !== 2'(order[i]))
                $display("FAIL rr_order[%0d]: gnt=%b id=%0d want onehot %0d", i, r.g, r.rid, order[i]);
            else n_pass++;
            handshake();
        end
        bus.req_i = '0;
        @(negedge clk);
    endtask

    task automatic test_back_pressure();
        xres_t r;
        logic [63:0] held;
        set_req(0, 64'hCAFE_0000_1111_2222, 6'd3, 16'd7);
        bus.req_i = 4'b0001;
        void'(rr_pick(bus.req_i));
        xfer(1'b1, r);
        held = r.rdat;
        set_req(1, 64'h0BAD_F00D, 6'd2, 16'd3);
        bus.req_i = 4'b0010;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.rsp_valid_o !== 1'b1 || bus.rsp_dat_o !== held || bus.gnt_o !== 4'b0000)
                $display("FAIL bp_hold[%0d]: valid=%b dat=%h gnt=%b want 1/%h/0000", i, bus.rsp_valid_o, bus.rsp_dat_o, bus.gnt_o, held);
            else n_pass++;
        end
        handshake();
        void'(rr_pick(bus.req_i));
        xfer(1'b1, r);
        n_checks++;
        if (r.tmo || r.g !== 4'b0010 || r.lat_g != 1 || r.rdat !== exp_rsp(64'h0BAD_F00D, 2))
            $display("FAIL bp_next: gnt=%b lat=%0d dat=%h want 0010/1/%h", r.g, r.lat_g, r.rdat, exp_rsp(64'h0BAD_F00D, 2));
        else n_pass++;
        handshake();
    endtask

    task automatic test_reset_mid();
        int  cyc;
        bit  bad;
        set_req(0, 64'h0000_0000_DEAD_BEEF, 6'd5, 16'd9);
        bus.req_i = 4'b0001;
        @(negedge clk);
        n_checks++;
        if (bus.gnt_o !== 4'b0001) $display("FAIL mid_gnt: gnt=%b want 0001", bus.gnt_o);
        else n_pass++;
        eng_hold = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.busy_o !== 1'b1 || bus.rsp_valid_o !== 1'b0)
            $display("FAIL mid_busy: busy=%b valid=%b want 1/0", bus.busy_o, bus.rsp_valid_o);
        else n_pass++;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.gnt_o !== 4'b0000 || bus.rsp_valid_o !== 1'b0 || bus.busy_o !== 1'b0) bad = 1;
        end
        n_checks++;
        if (bad) $display("FAIL mid_quiet: activity seen while engine not idle, want none");
        else n_pass++;
        n_checks++;
        if (bus.rsp_dat_o !== 64'h0 || bus.rsp_id_o !== 2'd0)
            $display("FAIL mid_rsp_clr: dat=%h id=%0d want 0/0", bus.rsp_dat_o, bus.rsp_id_o);
        else n_pass++;
        eng_hold = 1'b0;
        void'(rr_pick(bus.req_i));
        @(negedge clk);
        n_checks++;
        if (bus.gnt_o !== 4'b0001) $display("FAIL mid_regrant: gnt=%b want 0001", bus.gnt_o);
        else n_pass++;
        bus.req_i = '0;
        cyc = 0;
        while (!bus.rsp_valid_o && cyc < 200) begin @(negedge clk); cyc++; end
        n_checks++;
        if (bus.rsp_valid_o !== 1'b1 || bus.rsp_dat_o !== exp_rsp(64'hDEAD_BEEF, 5))
            $display("FAIL mid_resp: valid=%b dat=%h want 1/%h", bus.rsp_valid_o, bus.rsp_dat_o, exp_rsp(64'hDEAD_BEEF, 5));
        else n_pass++;
        handshake();
    endtask

    task automatic test_random();
        xres_t r;
        int w;
        logic [3:0] add;
        for (int it = 0; it < 25; it++) begin
            add = 4'($urandom_range(0, 15));
            if ((bus.req_i | add) == 4'b0) add = 4'b1 << $urandom_range(0, 3);
            for (int k = 0; k < NREQ; k++) begin
                if (add[k] && !bus.req_i[k]) begin
                    set_req(k, {$urandom, $urandom},
                            ($urandom_range(0, 7) == 0) ? 6'd63 : 6'($urandom_range(0, 9)),
                            16'($urandom));
                    bus.req_i[k] = 1'b1;
                end
            end
            w = rr_pick(bus.req_i);
            xfer(1'b1, r);
            n_checks++;
            if (r.tmo || r.g !== 4'(1 << w) || r.lat_g != 1)
                $display("FAIL rnd_gnt[%0d]: gnt=%b lat=%0d want onehot %0d lat 1", it, r.g, r.lat_g, w);
            else n_pass++;
            n_checks++;
            if (r.pd !== t_dat[w] || r.pb !== t_bits[w] || r.pbaud !== t_baud[w])
                $display("FAIL rnd_payload[%0d]: dat=%h bits=%0d baud=%0d want %h/%0d/%0d", it, r.pd, r.pb, r.pbaud, t_dat[w], t_bits[w], t_baud[w]);
            else n_pass++;
            n_checks++;
            if (r.rid !== 2'(w) || r.rdat !== exp_rsp(t_dat[w], int'(t_bits[w])) || r.lat_r != exp_lat(int'(t_bits[w])))
                $display("FAIL rnd_rsp[%0d]: id=%0d dat=%h lat=%0d want %0d/%h/%0d", it, r.rid, r.rdat, r.lat_r, w, exp_rsp(t_dat[w], int'(t_bits[w])), exp_lat(int'(t_bits[w])));
            else n_pass++;
            handshake();
        end
        bus.req_i = '0;
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        m_ptr    = 0;
        eng_hold = 1'b0;
        rst_n    = 1'b0;
        bus.req_i       = '0;
        bus.req_dat_i   = '0;
        bus.req_bits_i  = '0;
        bus.req_baud_i  = '0;
        bus.rsp_ready_i = 1'b0;
        eng_sh  = '0;
        eng_cnt = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_zero_bits();
        test_align();
        test_round_robin();
        test_back_pressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_xst_sched

`default_nettype wire
